// File: rtl/fsm_sync.sv
// fsm_sync: lock detector for a periodic, asynchronous RF-detect strobe.
// rfin is synchronized and edge-detected, and the interval between rising
// edges is measured. 'state' goes high after LOCK_COUNT consecutive
// in-window periods. It drops on an out-of-window pulse, or on a timeout
// when no pulse arrives within PERIOD_MAX cycles.
// sh_en gets its own plain two-flop synchronizer for downstream shift logic.
// Optional build macro FSM_SYNC_SHEN_GATE_EN: when it is defined,
// sh_en_sync2 is qualified by 'state', so shift enables only pass while
// LOCKED.
module fsm_sync #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_MIN = 9500,
  parameter int PERIOD_MAX = 10500,
  parameter int LOCK_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rfin,
  input  logic sh_en,
  output logic state,
  output logic sh_en_sync2
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } fsmState_t;

  localparam int GC_W = $clog2(LOCK_COUNT + 1);

  // The measured period is one bit wider than the counter. This lets
  // icnt+1 be formed without wrapping when the counter is saturated.
  localparam logic [CNT_W:0]   LP_MIN      = (CNT_W + 1)'(PERIOD_MIN);
  localparam logic [CNT_W:0]   LP_MAX      = (CNT_W + 1)'(PERIOD_MAX);
  localparam logic [CNT_W:0]   LP_ONE      = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] LP_ICNT_SAT = {CNT_W{1'b1}};
  localparam logic [GC_W-1:0]  LP_LOCK     = GC_W'(LOCK_COUNT);
  localparam logic [GC_W-1:0]  LP_GC_ONE   = GC_W'(1);

  logic            r_rfSync1;
  logic            r_rfSync2;
  logic            r_rfSync3;
  logic            r_shSync1;
  logic            r_shSync2;
  logic [CNT_W-1:0] r_icnt;
  logic [GC_W-1:0] r_gcnt;
  fsmState_t       r_fsmState;
  logic            r_state;

  logic            w_rfPulse;
  logic [CNT_W:0]  w_period;
  logic            w_inWindow;
  logic            w_overrun;
  logic [GC_W-1:0] w_gcntInc;
  fsmState_t       w_nextState;
  logic [GC_W-1:0] w_nextGcnt;
  logic [CNT_W-1:0] w_nextIcnt;

  // Three-flop chain on rfin: two flops for metastability, the third for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rfSync1 <= 1'b0;
      r_rfSync2 <= 1'b0;
      r_rfSync3 <= 1'b0;
    end else begin
      r_rfSync1 <= rfin;
      r_rfSync2 <= r_rfSync1;
      r_rfSync3 <= r_rfSync2;
    end
  end

  // Two-flop synchronizer for sh_en; level is passed through, no edge detect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shSync1 <= 1'b0;
      r_shSync2 <= 1'b0;
    end else begin
      r_shSync1 <= sh_en;
      r_shSync2 <= r_shSync1;
    end
  end

  // Rising-edge strobe. A long rfin high time still yields a single pulse.
  assign w_rfPulse = r_rfSync2 & ~r_rfSync3;

  // Period ending in this cycle, and whether it is acceptable or already overdue.
  assign w_period   = {1'b0, r_icnt} + LP_ONE;
  assign w_inWindow = (w_period >= LP_MIN) && (w_period <= LP_MAX);
  assign w_overrun  = (w_period > LP_MAX);
  assign w_gcntInc  = r_gcnt + LP_GC_ONE;

  // Interval counter restarts on every pulse and otherwise saturates.
  // Saturating means a very long gap can never wrap back into the window.
  always_comb begin
    w_nextIcnt = r_icnt;
    if (w_rfPulse) begin
      w_nextIcnt = '0;
    end else if (r_icnt != LP_ICNT_SAT) begin
      w_nextIcnt = r_icnt + 1'b1;
    end
  end

  // Next-state and good-count logic. A pulse always takes precedence over a
  // timeout in the same cycle.
  always_comb begin
    w_nextState = r_fsmState;
    w_nextGcnt  = r_gcnt;
    case (r_fsmState)
      IDLE: begin
        if (w_rfPulse) begin
          w_nextState = ACQUIRE;
          w_nextGcnt  = '0;
        end
      end
      ACQUIRE: begin
        if (w_rfPulse) begin
          if (w_inWindow) begin
            if (w_gcntInc >= LP_LOCK) begin
              w_nextState = LOCKED;
              w_nextGcnt  = LP_LOCK;
            end else begin
              w_nextGcnt = w_gcntInc;
            end
          end else begin
            w_nextGcnt = '0;
          end
        end else if (w_overrun) begin
          w_nextGcnt = '0;
        end
      end
      LOCKED: begin
        if (w_rfPulse) begin
          if (!w_inWindow) begin
            w_nextState = ACQUIRE;
            w_nextGcnt  = '0;
          end
        end else if (w_overrun) begin
          w_nextState = ACQUIRE;
          w_nextGcnt  = '0;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGcnt  = '0;
      end
    endcase
  end

  // State, counters and the registered lock flag all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsmState <= IDLE;
      r_gcnt     <= '0;
      r_icnt     <= '0;
      r_state    <= 1'b0;
    end else begin
      r_fsmState <= w_nextState;
      r_gcnt     <= w_nextGcnt;
      r_icnt     <= w_nextIcnt;
      r_state    <= (w_nextState == LOCKED);
    end
  end

  assign state = r_state;

`ifdef FSM_SYNC_SHEN_GATE_EN
  assign sh_en_sync2 = r_shSync2 & r_state;
`else
  assign sh_en_sync2 = r_shSync2;
`endif

endmodule

// File: tb/tb_fsm_sync.sv
// tb_fsm_sync: scoreboard bench for fsm_sync.
// The DUT is built with a 1000-cycle nominal period (window 950..1050). This
// keeps run time short. Expected output values are queued together with the
// cycle they belong to, and then compared on the falling edge of that cycle.
module tb_fsm_sync;

  localparam int CNT_W = 11;
  localparam int PMIN  = 950;
  localparam int PMAX  = 1050;
  localparam int LOCKN = 4;

`ifdef FSM_SYNC_SHEN_GATE_EN
  localparam logic GATED = 1'b1;
`else
  localparam logic GATED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rfin;
  logic sh_en;
  logic state;
  logic sh_en_sync2;

  int cyc = 0;
  int checkCount = 0;
  int failCount = 0;

  int    sbCyc[$];
  int    sbSig[$];
  logic  sbExp[$];
  string sbTag[$];

  fsm_sync #(
    .CNT_W(CNT_W),
    .PERIOD_MIN(PMIN),
    .PERIOD_MAX(PMAX),
    .LOCK_COUNT(LOCKN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rfin(rfin),
    .sh_en(sh_en),
    .state(state),
    .sh_en_sync2(sh_en_sync2)
  );

  // 10-cycle-period clock with a running count of rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  // sig 0 = state, sig 1 = sh_en_sync2
  task automatic expectOut(input int c, input int sig, input logic v, input string tag);
    sbCyc.push_back(c);
    sbSig.push_back(sig);
    sbExp.push_back(v);
    sbTag.push_back(tag);
  endtask

  task automatic waitUntilCyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // rfin high for 'width' cycles, first sampled at rising edge k.
  task automatic applyStimulus(input int k, input int width);
    waitUntilCyc(k - 1);
    rfin = 1'b1;
    repeat (width) @(negedge clk);
    rfin = 1'b0;
  endtask

  // sh_en high for 'width' cycles, first sampled at edge c+1. It must appear
  // at edges c+2..c+width+1.
  task automatic applyShEn(input int c, input int width, input logic highVal);
    expectOut(c + 1, 1, 1'b0, "sh_before");
    for (int i = 0; i < width; i++) expectOut(c + 2 + i, 1, highVal, "sh_high");
    expectOut(c + width + 2, 1, 1'b0, "sh_after");
    waitUntilCyc(c);
    sh_en = 1'b1;
    repeat (width) @(negedge clk);
    sh_en = 1'b0;
  endtask

  // Scoreboard: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sbCyc.size() - 1; i >= 0; i--) begin
      if (sbCyc[i] <= cyc) begin
        if (sbCyc[i] < cyc)
          checkOutput({sbTag[i], "_stale"}, cyc, sbCyc[i]);
        else if (sbSig[i] == 0)
          checkOutput(sbTag[i], 32'(state), 32'(sbExp[i]));
        else
          checkOutput(sbTag[i], 32'(sh_en_sync2), 32'(sbExp[i]));
        sbCyc.delete(i);
        sbSig.delete(i);
        sbExp.delete(i);
        sbTag.delete(i);
      end
    end
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges with both async inputs high.
    rst   = 1'b0;
    rfin  = 1'b1;
    sh_en = 1'b1;
    expectOut(1, 0, 1'b0, "rst_state1");
    expectOut(1, 1, 1'b0, "rst_sh1");
    expectOut(2, 0, 1'b0, "rst_state2");
    expectOut(2, 1, 1'b0, "rst_sh2");
    waitUntilCyc(2);
    rst   = 1'b1;
    rfin  = 1'b0;
    sh_en = 1'b0;
    expectOut(5, 0, 1'b0, "idle_state");

    // sh_en while unlocked: passes only in the ungated build.
    applyShEn(10, 1, ~GATED);

    // Lock acquisition: reference pulse plus four 1000-cycle periods. The
    // third pulse is 6 cycles wide and must still count as a single edge.
    expectOut(102, 0, 1'b0, "acq_ref");
    expectOut(3102, 0, 1'b0, "acq_pulse4");
    expectOut(4101, 0, 1'b0, "acq_before_lock");
    expectOut(4102, 0, 1'b1, "acq_lock");
    applyStimulus(100, 1);
    applyStimulus(1100, 1);
    applyStimulus(2100, 6);
    applyStimulus(3100, 1);
    applyStimulus(4100, 1);

    // sh_en while locked: passes in both builds, width preserved.
    applyShEn(4500, 1, 1'b1);
    applyShEn(4600, 3, 1'b1);

    // Jitter and window edges (980, 1020, 990, 1010, 1050, 950), then an early pulse at 300.
    expectOut(5082, 0, 1'b1, "jit_980");
    expectOut(6102, 0, 1'b1, "jit_1020");
    expectOut(7092, 0, 1'b1, "jit_990");
    expectOut(8102, 0, 1'b1, "jit_1010");
    expectOut(9151, 0, 1'b1, "max_pre");
    expectOut(9152, 0, 1'b1, "max_1050");
    expectOut(10102, 0, 1'b1, "min_950");
    expectOut(10401, 0, 1'b1, "early_pre");
    expectOut(10402, 0, 1'b0, "early_drop");
    applyStimulus(5080, 1);
    applyStimulus(6100, 1);
    applyStimulus(7090, 1);
    applyStimulus(8100, 1);
    applyStimulus(9150, 1);
    applyStimulus(10100, 1);
    applyStimulus(10400, 1);

    // Relock from the early pulse. A 949 period and a 1051 period each reset the run.
    expectOut(11402, 0, 1'b0, "relock_g1");
    expectOut(14351, 0, 1'b0, "relock_949");
    expectOut(15402, 0, 1'b0, "relock_1051");
    expectOut(18402, 0, 1'b0, "relock_g3");
    expectOut(19401, 0, 1'b0, "relock_pre");
    expectOut(19402, 0, 1'b1, "relock_lock");
    applyStimulus(11400, 1);
    applyStimulus(12400, 1);
    applyStimulus(13400, 1);
    applyStimulus(14349, 1);
    applyStimulus(15400, 1);
    applyStimulus(16400, 1);
    applyStimulus(17400, 1);
    applyStimulus(18400, 1);
    applyStimulus(19400, 1);

    // Timeout: the last pulse was evaluated at edge 19402, so icnt hits 1050 after
    // edge 20452 and the state falls at edge 20453.
    expectOut(20452, 0, 1'b1, "timeout_pre");
    expectOut(20453, 0, 1'b0, "timeout_drop");

    // After a 3047-cycle gap the counter is saturated, so this pulse is only a
    // reference. A wrapping counter would wrongly see P=1000.
    expectOut(22450, 0, 1'b0, "sat_ref");
    expectOut(25450, 0, 1'b0, "sat_g3");
    expectOut(26449, 0, 1'b0, "sat_pre");
    expectOut(26450, 0, 1'b1, "sat_lock");
    applyStimulus(22448, 1);
    applyStimulus(23448, 1);
    applyStimulus(24448, 1);
    applyStimulus(25448, 1);
    applyStimulus(26448, 1);

    // Reset while LOCKED, then a single pulse only moves IDLE to ACQUIRE.
    expectOut(26600, 0, 1'b1, "midrst_pre");
    expectOut(26601, 0, 1'b0, "midrst_drop");
    expectOut(26602, 0, 1'b0, "midrst_after");
    waitUntilCyc(26600);
    rst = 1'b0;
    waitUntilCyc(26601);
    rst = 1'b1;
    expectOut(26702, 0, 1'b0, "postrst_ref");
    applyStimulus(26700, 1);

    waitUntilCyc(26720);
    checkOutput("sb_drained", sbCyc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
